// File: rtl/bram_readout_pkg.sv
// Shared definitions for the capture-BRAM read-side sequencer.
//   state_t      : sequencer states IDLE / READ / DRAIN / DONE
//   BRAM_WORD_W  : width of the BRAM output word
//   fifo_depth() : output FIFO depth for a given BRAM read latency
package bram_readout_pkg;

  localparam int unsigned BRAM_WORD_W = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  // One slot per read that can be in flight plus one for the sample on the output.
  function automatic int unsigned fifo_depth(input int unsigned rd_latency);
    return rd_latency + 1;
  endfunction

endpackage

// File: rtl/readout_fifo.sv
// Small synchronous FIFO holding returned samples until the consumer takes them.
// The caller guarantees no push when full and no pop when empty.
// Ports:
//   clock, i_reset : clock, synchronous active-high reset (flushes contents)
//   push_i, data_i : write strobe and sample
//   pop_i          : read strobe (head advances)
//   data_o         : head of queue, stable until popped
//   count_o        : current occupancy
//   empty_o        : occupancy is zero
module readout_fifo
  import bram_readout_pkg::*;
#(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned WIDTH = 13
) (
  input  logic                         clock,
  input  logic                         i_reset,
  input  logic                         push_i,
  input  logic [WIDTH-1:0]             data_i,
  input  logic                         pop_i,
  output logic [WIDTH-1:0]             data_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_o,
  output logic                         empty_o
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [CNT_W-1:0] count_q;

  // Pointer increment with wrap for non-power-of-two depths.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // Storage is cleared on reset so the idle sample output reads zero.
  always_ff @(posedge clock) begin
    if (i_reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      if (push_i) begin
        mem_q[wr_ptr_q] <= data_i;
        wr_ptr_q        <= ptr_inc(wr_ptr_q);
      end
      if (pop_i) begin
        rd_ptr_q <= ptr_inc(rd_ptr_q);
      end
      // Simultaneous push and pop leaves occupancy unchanged.
      case ({push_i, pop_i})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  assign data_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;
  assign empty_o = (count_q == '0);

endmodule

// File: rtl/bram_readout.sv
// Read-side sequencer for the FIR capture BRAM. On a start pulse with a full
// capture buffer it reads addresses 0..DEPTH-1, absorbs the BRAM read latency
// through a credit-limited output FIFO and streams samples on valid/ready.
// Optional build macro: BRAM_READOUT_LOOP_EN -- address wraps after DEPTH-1 and
// reading repeats until a further i_start, which drains and finishes.
// Ports:
//   clock, i_reset      : clock, synchronous active-high reset
//   i_start, i_mem_full : start pulse, capture-complete flag
//   o_read_addr         : BRAM read address (advances only on an issued read)
//   o_read_enable       : BRAM read enable, high exactly when a read is issued
//   i_read_data         : BRAM output word; low NB_DATA bits are the sample
//   o_data, o_valid     : output sample stream
//   i_ready             : consumer accepts when o_valid && i_ready
//   o_busy              : high in READ/DRAIN
//   o_done              : one-cycle pulse after the last sample is accepted
module bram_readout
  import bram_readout_pkg::*;
#(
  parameter int unsigned NB_ADDR    = 11,
  parameter int unsigned NB_DATA    = 13,
  parameter int unsigned DEPTH      = 2047,
  parameter int unsigned RD_LATENCY = 1
) (
  input  logic                   clock,
  input  logic                   i_reset,
  input  logic                   i_start,
  input  logic                   i_mem_full,
  output logic [NB_ADDR-1:0]     o_read_addr,
  output logic                   o_read_enable,
  input  logic [BRAM_WORD_W-1:0] i_read_data,
  output logic [NB_DATA-1:0]     o_data,
  output logic                   o_valid,
  input  logic                   i_ready,
  output logic                   o_busy,
  output logic                   o_done
);

  localparam int unsigned FIFO_DEPTH = fifo_depth(RD_LATENCY);
  localparam int unsigned CNT_W      = $clog2(FIFO_DEPTH + 1);
  // One spare bit so occupancy + in-flight + a pop credit never wraps.
  localparam int unsigned LOAD_W     = CNT_W + 1;
  localparam logic [NB_ADDR-1:0] LAST_ADDR = NB_ADDR'(DEPTH - 1);

  // Elaboration-time parameter sanity.
  if (DEPTH == 0 || DEPTH > (2 ** NB_ADDR)) begin : g_bad_depth
    $error("bram_readout: DEPTH must be in 1..2**NB_ADDR");
  end
  if (RD_LATENCY < 1 || RD_LATENCY > 2) begin : g_bad_latency
    $error("bram_readout: RD_LATENCY must be 1 or 2");
  end
  if (NB_DATA > BRAM_WORD_W) begin : g_bad_width
    $error("bram_readout: NB_DATA exceeds the BRAM word width");
  end

  state_t                state_q,    state_d;
  logic [NB_ADDR-1:0]    addr_q,     addr_d;
  logic [RD_LATENCY-1:0] inflight_q, inflight_d;
  logic                  busy_q,     busy_d;
  logic                  done_q,     done_d;

  logic [CNT_W-1:0]      fifo_count;
  logic                  fifo_empty;
  logic                  push_c;
  logic                  pop_c;
  logic                  issue_c;
  logic                  drained_c;
  logic [LOAD_W-1:0]     inflight_cnt_c;
  logic [LOAD_W-1:0]     load_c;
  logic                  unused_rd_bits;

  // Output queue for returned samples.
  readout_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (NB_DATA)
  ) u_fifo (
    .clock   (clock),
    .i_reset (i_reset),
    .push_i  (push_c),
    .data_i  (i_read_data[NB_DATA-1:0]),
    .pop_i   (pop_c),
    .data_o  (o_data),
    .count_o (fifo_count),
    .empty_o (fifo_empty)
  );

  assign unused_rd_bits = ^i_read_data[BRAM_WORD_W-1:NB_DATA];

  // Bit k of inflight_q marks a read issued k+1 cycles ago; the oldest bit
  // lines up with the BRAM data arriving this cycle.
  assign push_c  = inflight_q[RD_LATENCY-1];
  assign o_valid = ~fifo_empty;
  assign pop_c   = o_valid & i_ready;

  // Everything that will need a FIFO slot: stored samples plus reads in flight.
  always_comb begin
    inflight_cnt_c = '0;
    for (int i = 0; i < RD_LATENCY; i++) begin
      inflight_cnt_c = inflight_cnt_c + LOAD_W'(inflight_q[i]);
    end
  end

  assign load_c = LOAD_W'(fifo_count) + inflight_cnt_c;

  // A slot freed by this cycle's pop counts as a credit, which is what allows
  // one sample per cycle with only RD_LATENCY+1 entries of storage.
  assign issue_c   = (state_q == READ) && (load_c < LOAD_W'(FIFO_DEPTH) + LOAD_W'(pop_c));
  // Nothing left after this cycle's pop: lets o_done follow the last accept directly.
  assign drained_c = (load_c == LOAD_W'(pop_c));

  // In-flight shift register: new read enters at bit 0.
  always_comb begin
    inflight_d    = '0;
    inflight_d[0] = issue_c;
    for (int i = 1; i < RD_LATENCY; i++) begin
      inflight_d[i] = inflight_q[i-1];
    end
  end

  // Next-state, address and status logic.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    busy_d  = 1'b0;
    done_d  = 1'b0;

    if (issue_c) begin
      addr_d = addr_q + NB_ADDR'(1);
    end

    case (state_q)
      IDLE: begin
        // A fresh pass always starts from address 0.
        if (i_start && i_mem_full) begin
          state_d = READ;
          addr_d  = '0;
        end
      end
      READ: begin
        if (issue_c && (addr_q == LAST_ADDR)) begin
`ifdef BRAM_READOUT_LOOP_EN
          addr_d = '0;
`else
          state_d = DRAIN;
`endif
        end
`ifdef BRAM_READOUT_LOOP_EN
        if (i_start) begin
          state_d = DRAIN;
        end
`endif
      end
      DRAIN: begin
        if (drained_c) begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d == READ) || (state_d == DRAIN);
    done_d = (state_d == DONE);
  end

  // Sequencer registers.
  always_ff @(posedge clock) begin
    if (i_reset) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      inflight_q <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      inflight_q <= inflight_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign o_read_addr   = addr_q;
  assign o_read_enable = issue_c;
  assign o_busy        = busy_q;
  assign o_done        = done_q;

endmodule

// File: tb/tb_bram_readout.sv
// Self-checking bench for bram_readout with a behavioural BRAM and a
// stream-level reference: the k-th accepted sample must equal RAM[k mod DEPTH]
// truncated to NB_DATA bits, the k-th issued read must target k mod DEPTH, and
// reads issued minus samples accepted never exceeds the FIFO depth.
module tb_bram_readout;

  localparam int unsigned NB_ADDR    = 11;
  localparam int unsigned NB_DATA    = 13;
  localparam int unsigned DEPTH      = 2047;
  localparam int unsigned RD_LATENCY = 1;
  localparam int unsigned FIFO_DEPTH = RD_LATENCY + 1;

  logic               clock;
  logic               i_reset;
  logic               i_start;
  logic               i_mem_full;
  logic [NB_ADDR-1:0] o_read_addr;
  logic               o_read_enable;
  logic [31:0]        i_read_data;
  logic [NB_DATA-1:0] o_data;
  logic               o_valid;
  logic               i_ready;
  logic               o_busy;
  logic               o_done;

  bram_readout #(
    .NB_ADDR    (NB_ADDR),
    .NB_DATA    (NB_DATA),
    .DEPTH      (DEPTH),
    .RD_LATENCY (RD_LATENCY)
  ) dut (
    .clock         (clock),
    .i_reset       (i_reset),
    .i_start       (i_start),
    .i_mem_full    (i_mem_full),
    .o_read_addr   (o_read_addr),
    .o_read_enable (o_read_enable),
    .i_read_data   (i_read_data),
    .o_data        (o_data),
    .o_valid       (o_valid),
    .i_ready       (i_ready),
    .o_busy        (o_busy),
    .o_done        (o_done)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Behavioural BRAM: data for a read appears RD_LATENCY edges after the enable.
  logic [31:0] ram     [DEPTH];
  logic [31:0] rd_pipe [RD_LATENCY];
  always @(posedge clock) begin
    if (o_read_enable) rd_pipe[0] <= ram[o_read_addr];
    for (int i = 1; i < RD_LATENCY; i++) rd_pipe[i] <= rd_pipe[i-1];
  end
  assign i_read_data = rd_pipe[RD_LATENCY-1];

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int n_issued, n_acc, done_cnt, en_cnt, busy_cnt;
  int start_cyc, first_valid_cyc, last_acc_cyc;
  bit first_seen;
  bit prev_valid, prev_ready;
  logic [NB_DATA-1:0] prev_data;
  bit ready_random = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Per-cycle reference checks, sampled 1 time unit after inputs settle.
  task automatic observe();
    logic [NB_DATA-1:0] exp_d;
    if (o_valid && !first_seen) begin
      first_seen      = 1'b1;
      first_valid_cyc = cyc;
    end
    if (prev_valid && !prev_ready) begin
      check("hold_valid", 32'(o_valid), 32'd1);
      check("hold_data", 32'(o_data), 32'(prev_data));
    end
    if (o_valid && i_ready) begin
      exp_d = ram[n_acc % DEPTH][NB_DATA-1:0];
      check("sample", 32'(o_data), 32'(exp_d));
      n_acc++;
      last_acc_cyc = cyc;
    end
    if (o_read_enable) begin
      check("rd_addr", 32'(o_read_addr), 32'(n_issued % DEPTH));
      n_issued++;
      en_cnt++;
      check("no_overflow", 32'(n_issued - n_acc <= FIFO_DEPTH), 32'd1);
    end
    if (o_busy) busy_cnt++;
    if (o_done) begin
      done_cnt++;
      check("done_after_last_accept", 32'(cyc - last_acc_cyc), 32'd1);
      check("done_all_delivered", 32'(n_acc), 32'(n_issued));
    end
    prev_valid = o_valid;
    prev_ready = i_ready;
    prev_data  = o_data;
  endtask

  // Called at a falling edge after this cycle's inputs are set.
  task automatic cycle();
    #1;
    observe();
    @(negedge clock);
    cyc++;
    if (ready_random) i_ready = 1'($urandom_range(1, 0));
  endtask

  task automatic begin_run();
    n_issued = 0; n_acc = 0; done_cnt = 0; en_cnt = 0; busy_cnt = 0;
    first_seen = 1'b0; last_acc_cyc = -100;
    i_start   = 1'b1;
    start_cyc = cyc;
    cycle();
    i_start = 1'b0;
  endtask

  task automatic run_to_done(input int budget);
    int n = 0;
    while (done_cnt == 0 && n < budget) begin
      cycle();
      n++;
    end
    check("done_within_budget", 32'(done_cnt != 0), 32'd1);
    cycle();
    cycle();
  endtask

  task automatic check_single_pass(input string tag);
    check({tag, "_issued"}, 32'(n_issued), 32'(DEPTH));
    check({tag, "_accepted"}, 32'(n_acc), 32'(DEPTH));
    check({tag, "_done_pulses"}, 32'(done_cnt), 32'd1);
    check({tag, "_busy_after"}, 32'(o_busy), 32'd0);
  endtask

  task automatic check_zero(input string tag);
    #1;
    check({tag, "_addr"}, 32'(o_read_addr), 32'd0);
    check({tag, "_rden"}, 32'(o_read_enable), 32'd0);
    check({tag, "_data"}, 32'(o_data), 32'd0);
    check({tag, "_valid"}, 32'(o_valid), 32'd0);
    check({tag, "_busy"}, 32'(o_busy), 32'd0);
    check({tag, "_done"}, 32'(o_done), 32'd0);
  endtask

  initial begin
    int n;
    i_reset = 1'b1; i_start = 1'b0; i_mem_full = 1'b0; i_ready = 1'b0;
    for (int k = 0; k < DEPTH; k++) ram[k] = 32'(k);
    for (int i = 0; i < RD_LATENCY; i++) rd_pipe[i] = '0;
    repeat (3) @(negedge clock);
    i_reset = 1'b0;
    check_zero("reset");

    // Start without a full buffer is ignored.
    i_mem_full = 1'b0;
    begin_run();
    repeat (20) cycle();
    check("nofull_reads", 32'(en_cnt), 32'd0);
    check("nofull_busy", 32'(busy_cnt), 32'd0);
    check("nofull_done", 32'(done_cnt), 32'd0);
    i_mem_full = 1'b1;

`ifndef BRAM_READOUT_LOOP_EN
    // Full pass with RAM[k]=k, consumer always ready.
    i_ready = 1'b1;
    begin_run();
    run_to_done(DEPTH + 50);
    // o_valid rises on the (RD_LATENCY+1)-th edge after the edge sampling i_start.
    check("first_valid_latency", 32'(first_valid_cyc - start_cyc), 32'(RD_LATENCY + 2));
    check("back_to_back", 32'(last_acc_cyc - first_valid_cyc), 32'(DEPTH - 1));
    check_single_pass("pass1");

    // Random backpressure on random data, with a stray start that must be ignored.
    for (int k = 0; k < DEPTH; k++) ram[k] = $urandom;
    ready_random = 1'b1;
    begin_run();
    n = 0;
    while (done_cnt == 0 && n < 20000) begin
      i_start = (n == 500);
      cycle();
      n++;
    end
    i_start = 1'b0;
    check("rand_done_seen", 32'(done_cnt != 0), 32'd1);
    cycle();
    cycle();
    ready_random = 1'b0;
    check_single_pass("rand");

    // Consumer stalled from the start: only FIFO_DEPTH reads may go out.
    i_ready = 1'b0;
    begin_run();
    repeat (30) cycle();
    check("stall_reads", 32'(n_issued), 32'(FIFO_DEPTH));
    check("stall_rden_low", 32'(o_read_enable), 32'd0);
    check("stall_valid", 32'(o_valid), 32'd1);
    i_ready = 1'b1;
    run_to_done(DEPTH + 50);
    check_single_pass("stall");

    // Reset in the middle of a transfer, then a clean restart.
    i_ready = 1'b1;
    begin_run();
    n = 0;
    while (n_acc < 1000 && n < 3000) begin
      cycle();
      n++;
    end
    check("reached_sample_1000", 32'(n_acc), 32'd1000);
    i_reset = 1'b1;
    i_ready = 1'b0;
    cycle();
    i_reset = 1'b0;
    i_ready = 1'b1;
    prev_valid = 1'b0;
    check_zero("midreset");
    repeat (5) cycle();
    check("midreset_no_done", 32'(done_cnt), 32'd0);
    begin_run();
    run_to_done(DEPTH + 50);
    check_single_pass("restart");
`else
    // Loop mode: 2.5 passes, then a second start drains and finishes.
    for (int k = 0; k < DEPTH; k++) ram[k] = $urandom;
    ready_random = 1'b1;
    begin_run();
    n = 0;
    while (n_acc < (5 * DEPTH) / 2 && n < 30000) begin
      cycle();
      n++;
    end
    check("loop_reached_2p5", 32'(n_acc >= (5 * DEPTH) / 2), 32'd1);
    check("loop_busy", 32'(o_busy), 32'd1);
    check("loop_no_done", 32'(done_cnt), 32'd0);
    i_start = 1'b1;
    cycle();
    i_start = 1'b0;
    run_to_done(200);
    ready_random = 1'b0;
    check("loop_done_pulses", 32'(done_cnt), 32'd1);
    check("loop_all_delivered", 32'(n_acc), 32'(n_issued));
    check("loop_busy_after", 32'(o_busy), 32'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
